// File: rtl/uart_cmd_seq_pkg.sv
// seg_uart_pkg: shared types and constants for the UART command sequencer.
//   state_e       : frame-assembly FSM states
//   SYNC_BYTE_DEF : default frame start marker
//   FRAME_LEN     : bytes per frame (sync, cmd, data_hi, data_lo, chk)
//   frame_chk()   : frame checksum helper
package seg_uart_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD  = 3'd1,
    DHI  = 3'd2,
    DLO  = 3'd3,
    CHK  = 3'd4
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         FRAME_LEN     = 5;

  // XOR checksum over the three payload bytes of a frame.
  function automatic logic [7:0] frame_chk(input logic [7:0] c,
                                           input logic [7:0] hi,
                                           input logic [7:0] lo);
    return c ^ hi ^ lo;
  endfunction

endpackage

// File: rtl/uart_cmd_seq_if.sv
// uart_cmd_seq_if: receiver-side and consumer-side signals of the command
// sequencer, bundled into one interface.
//   rx_rdy/rx_data : byte-ready flag and byte from the UART receiver
//   clr_rdy        : one-cycle pulse clearing the receiver's ready flag
//   clr_cmd_rdy    : consumer acknowledge of the held command
//   cmd_rdy/cmd/cmd_data : validated command and its operand
//   frame_err      : one-cycle pulse on checksum failure or timeout
//   overrun        : one-cycle pulse when an unacknowledged command is overwritten
// slave = the sequencer, master = the environment around it.
interface uart_cmd_seq_if;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rdy;
  logic        clr_cmd_rdy;
  logic        cmd_rdy;
  logic [7:0]  cmd;
  logic [15:0] cmd_data;
  logic        frame_err;
  logic        overrun;

  modport slave (
    input  rx_rdy, rx_data, clr_cmd_rdy,
    output clr_rdy, cmd_rdy, cmd, cmd_data, frame_err, overrun
  );

  modport master (
    output rx_rdy, rx_data, clr_cmd_rdy,
    input  clr_rdy, cmd_rdy, cmd, cmd_data, frame_err, overrun
  );
endinterface

// File: rtl/uart_cmd_seq_tmr.sv
// uart_frame_tmr: inter-byte gap counter.
//   clk, rst : clock and synchronous active-high reset
//   clr      : clear the count (byte accepted, or no frame in progress)
//   en       : count one cycle of silence
//   expired  : count has reached TIMEOUT_CYCLES-1
module uart_frame_tmr #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int              CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0]   LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_r;

  // Gap counter; saturates at LAST so it can never wrap back to a small value.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CW{1'b0}};
    end else if (clr) begin
      cnt_r <= {CW{1'b0}};
    end else if (en && !expired) begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  assign expired = (cnt_r == LAST);

endmodule

// File: rtl/uart_cmd_seq.sv
// uart_cmd_seq: assembles 5-byte frames {SYNC_BYTE, cmd, data_hi, data_lo, chk}
// from a UART receiver and presents validated commands to a consumer.
//   clk : sole clock, rising edge
//   rst : synchronous active-high reset
//   bus : uart_cmd_seq_if.slave (receiver handshake + command outputs)
// A byte is taken when rx_rdy=1 and clr_rdy=0; clr_rdy follows one cycle later,
// which also masks the receiver's still-high flag during that cycle.
module uart_cmd_seq
  import seg_uart_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_CYCLES = 50000
) (
  input  logic          clk,
  input  logic          rst,
  uart_cmd_seq_if.slave bus
);

  state_e      state_r, state_nxt;
  logic        accept_s, expired_s;
  logic        ld_cmd_s, ld_dhi_s, ld_dlo_s, commit_s, err_s;
  logic        clr_rdy_r, cmd_rdy_r, frame_err_r, overrun_r;
  logic [7:0]  cmd_sh_r, dhi_sh_r, dlo_sh_r, cmd_r;
  logic [15:0] cmd_data_r;

  assign accept_s = bus.rx_rdy & ~clr_rdy_r;

  // Counter is parked at zero in IDLE and restarts on every accepted byte.
  uart_frame_tmr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmr (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept_s | (state_r == IDLE)),
    .en      (state_r != IDLE),
    .expired (expired_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state and strobe decode; an accepted byte always beats a timeout.
  always_comb begin
    state_nxt = state_r;
    ld_cmd_s  = 1'b0;
    ld_dhi_s  = 1'b0;
    ld_dlo_s  = 1'b0;
    commit_s  = 1'b0;
    err_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s && (bus.rx_data == SYNC_BYTE)) begin
          state_nxt = CMD;
        end else begin
          state_nxt = IDLE;
        end
      end
      CMD: begin
        if (accept_s) begin
          ld_cmd_s  = 1'b1;
          state_nxt = DHI;
        end else if (expired_s) begin
          err_s     = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = CMD;
        end
      end
      DHI: begin
        if (accept_s) begin
          ld_dhi_s  = 1'b1;
          state_nxt = DLO;
        end else if (expired_s) begin
          err_s     = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = DHI;
        end
      end
      DLO: begin
        if (accept_s) begin
          ld_dlo_s  = 1'b1;
          state_nxt = CHK;
        end else if (expired_s) begin
          err_s     = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = DLO;
        end
      end
      CHK: begin
        if (accept_s) begin
          state_nxt = IDLE;
          if (bus.rx_data == frame_chk(cmd_sh_r, dhi_sh_r, dlo_sh_r)) begin
            commit_s = 1'b1;
          end else begin
            err_s = 1'b1;
          end
        end else if (expired_s) begin
          err_s     = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = CHK;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Shadow registers, command outputs and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_rdy_r   <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
      cmd_rdy_r   <= 1'b0;
      cmd_sh_r    <= 8'h00;
      dhi_sh_r    <= 8'h00;
      dlo_sh_r    <= 8'h00;
      cmd_r       <= 8'h00;
      cmd_data_r  <= 16'h0000;
    end else begin
      clr_rdy_r   <= accept_s;
      frame_err_r <= err_s;
      overrun_r   <= commit_s & cmd_rdy_r & ~bus.clr_cmd_rdy;
      if (ld_cmd_s) cmd_sh_r <= bus.rx_data;
      if (ld_dhi_s) dhi_sh_r <= bus.rx_data;
      if (ld_dlo_s) dlo_sh_r <= bus.rx_data;
      // A completing frame wins over a simultaneous acknowledge.
      if (commit_s) begin
        cmd_r      <= cmd_sh_r;
        cmd_data_r <= {dhi_sh_r, dlo_sh_r};
        cmd_rdy_r  <= 1'b1;
      end else if (bus.clr_cmd_rdy) begin
        cmd_rdy_r  <= 1'b0;
      end
    end
  end

  assign bus.clr_rdy   = clr_rdy_r;
  assign bus.cmd_rdy   = cmd_rdy_r;
  assign bus.cmd       = cmd_r;
  assign bus.cmd_data  = cmd_data_r;
  assign bus.frame_err = frame_err_r;
  assign bus.overrun   = overrun_r;

endmodule

// File: tb/tb_uart_cmd_seq.sv
// tb_uart_cmd_seq: directed + randomized stimulus for uart_cmd_seq, checked
// against a byte-stream frame model kept in the bench.
module tb_uart_cmd_seq;
  import seg_uart_pkg::*;

  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  uart_cmd_seq_if bus();

  uart_cmd_seq #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  int          pos = 0;        // bytes of the current frame seen (0 = hunting)
  int          last_acc = 0;   // cycle number of the last accepted frame byte
  logic [7:0]  fb [FRAME_LEN];
  logic        e_rdy = 1'b0;
  logic [7:0]  e_cmd = 8'h00;
  logic [15:0] e_data = 16'h0000;
  int          exp_clr = 0;
  int          exp_err_q[$];
  int          exp_ov_q[$];

  // observed pulses
  int          obs_clr = 0;
  int          obs_err_q[$];
  int          obs_ov_q[$];

  always @(negedge clk) begin
    if (bus.frame_err) obs_err_q.push_back(cyc);
    if (bus.overrun)   obs_ov_q.push_back(cyc);
    if (bus.clr_rdy)   obs_clr++;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // A frame that saw more than TMO edges of silence died TMO edges after its last byte.
  function automatic void model_timeout(input int now);
    if (pos != 0 && (now - last_acc) > TMO) begin
      exp_err_q.push_back(last_acc + TMO);
      pos = 0;
    end
  endfunction

  function automatic void model_byte(input logic [7:0] b, input int c, input logic ack);
    logic commit;
    commit = 1'b0;
    model_timeout(c);
    exp_clr++;
    if (pos == 0) begin
      if (b == 8'hA5) pos = 1;
    end else begin
      fb[pos] = b;
      pos++;
      if (pos == FRAME_LEN) begin
        pos = 0;
        if (fb[4] == (fb[1] ^ fb[2] ^ fb[3])) commit = 1'b1;
        else exp_err_q.push_back(c);
      end
    end
    last_acc = c;
    if (commit) begin
      if (e_rdy && !ack) exp_ov_q.push_back(c);
      e_rdy  = 1'b1;
      e_cmd  = fb[1];
      e_data = {fb[2], fb[3]};
    end else if (ack) begin
      e_rdy = 1'b0;
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic send_byte(input logic [7:0] b, input int pre_idle, input logic ack);
    int c;
    for (int i = 0; i < pre_idle; i++) begin
      @(posedge clk); #1;
    end
    bus.rx_rdy      = 1'b1;
    bus.rx_data     = b;
    bus.clr_cmd_rdy = ack;
    @(posedge clk); #1;
    c = cyc;
    bus.clr_cmd_rdy = 1'b0;
    model_byte(b, c, ack);
    check_eq("clr_rdy", 32'(bus.clr_rdy), 32'd1);
    check_eq("cmd_rdy", 32'(bus.cmd_rdy), 32'(e_rdy));
    check_eq("cmd", 32'(bus.cmd), 32'(e_cmd));
    check_eq("cmd_data", 32'(bus.cmd_data), 32'(e_data));
    // receiver flag stays high until it sees clr_rdy
    @(posedge clk); #1;
    bus.rx_rdy  = 1'b0;
    bus.rx_data = 8'($urandom);
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] hi, input logic [7:0] lo,
                            input logic [7:0] k, input int gap, input logic ack_last);
    send_byte(8'hA5, gap, 1'b0);
    send_byte(c, gap, 1'b0);
    send_byte(hi, gap, 1'b0);
    send_byte(lo, gap, 1'b0);
    send_byte(k, gap, ack_last);
  endtask

  task automatic ack_only();
    bus.clr_cmd_rdy = 1'b1;
    @(posedge clk); #1;
    bus.clr_cmd_rdy = 1'b0;
    e_rdy = 1'b0;
    check_eq("ack_cmd_rdy", 32'(bus.cmd_rdy), 32'd0);
    check_eq("ack_cmd_hold", 32'(bus.cmd), 32'(e_cmd));
  endtask

  // Let any pending timeout fire, then reconcile pulse histories.
  task automatic flush_check(input string tag);
    for (int i = 0; i < TMO + 4; i++) begin
      @(posedge clk); #1;
    end
    model_timeout(cyc);
    check_eq({tag, "_err_n"}, 32'(obs_err_q.size()), 32'(exp_err_q.size()));
    for (int i = 0; i < obs_err_q.size() && i < exp_err_q.size(); i++)
      check_eq({tag, "_err_cyc"}, 32'(obs_err_q[i]), 32'(exp_err_q[i]));
    check_eq({tag, "_ov_n"}, 32'(obs_ov_q.size()), 32'(exp_ov_q.size()));
    for (int i = 0; i < obs_ov_q.size() && i < exp_ov_q.size(); i++)
      check_eq({tag, "_ov_cyc"}, 32'(obs_ov_q[i]), 32'(exp_ov_q[i]));
    check_eq({tag, "_clr_n"}, 32'(obs_clr), 32'(exp_clr));
    check_eq({tag, "_cmd_rdy"}, 32'(bus.cmd_rdy), 32'(e_rdy));
    check_eq({tag, "_cmd"}, 32'(bus.cmd), 32'(e_cmd));
    check_eq({tag, "_data"}, 32'(bus.cmd_data), 32'(e_data));
    obs_err_q.delete(); exp_err_q.delete();
    obs_ov_q.delete();  exp_ov_q.delete();
    obs_clr = 0; exp_clr = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    pos = 0; e_rdy = 1'b0; e_cmd = 8'h00; e_data = 16'h0000;
    check_eq("rst_cmd_rdy", 32'(bus.cmd_rdy), 32'd0);
    check_eq("rst_cmd", 32'(bus.cmd), 32'd0);
    check_eq("rst_data", 32'(bus.cmd_data), 32'd0);
    check_eq("rst_clr_rdy", 32'(bus.clr_rdy), 32'd0);
    check_eq("rst_frame_err", 32'(bus.frame_err), 32'd0);
    check_eq("rst_overrun", 32'(bus.overrun), 32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int kind, gap;
    logic [7:0] c, hi, lo, k;
    rst = 1'b1;
    bus.rx_rdy = 1'b0;
    bus.rx_data = 8'h00;
    bus.clr_cmd_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    do_reset();

    // basic frame at ~10-cycle spacing
    send_frame(8'h10, 8'h12, 8'h34, 8'h36, 8, 1'b0);
    flush_check("good");
    ack_only();

    // bad checksum, then a good frame
    send_frame(8'h10, 8'h12, 8'h34, 8'h00, 0, 1'b0);
    send_frame(8'h01, 8'h00, 8'h02, 8'h03, 0, 1'b0);
    flush_check("badchk");
    ack_only();

    // timeout after two bytes, then a good frame
    send_byte(8'hA5, 0, 1'b0);
    send_byte(8'h10, 0, 1'b0);
    flush_check("tmo");
    send_frame(8'h22, 8'h33, 8'h44, 8'h55, 1, 1'b0);
    flush_check("after_tmo");

    // gap boundary: 16 edges continues, 17 edges times out
    send_byte(8'hA5, 0, 1'b0);
    send_byte(8'h10, 0, 1'b0);
    send_byte(8'h12, TMO - 2, 1'b0);
    send_byte(8'h34, 0, 1'b0);
    send_byte(8'h36, 0, 1'b0);
    flush_check("gap16");
    send_byte(8'hA5, 0, 1'b0);
    send_byte(8'h77, TMO - 1, 1'b0);
    flush_check("gap17");

    // overrun, then set-wins-over-ack
    send_frame(8'h01, 8'h02, 8'h03, 8'h00, 0, 1'b0);
    send_frame(8'h04, 8'h05, 8'h06, 8'h07, 0, 1'b0);
    flush_check("overrun");
    ack_only();
    send_frame(8'h08, 8'h09, 8'h0A, 8'h0B, 0, 1'b0);
    send_frame(8'h0C, 8'h0D, 8'h0E, 8'h0F, 0, 1'b1);
    flush_check("setwins");

    // leading garbage and sync-valued data bytes
    ack_only();
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'hFF, 0, 1'b0);
    send_frame(8'hA5, 8'h00, 8'h00, 8'hA5, 0, 1'b0);
    flush_check("resync");

    // reset mid-frame
    send_byte(8'hA5, 0, 1'b0);
    send_byte(8'h10, 0, 1'b0);
    send_byte(8'h12, 0, 1'b0);
    do_reset();
    flush_check("midrst");
    send_frame(8'h5A, 8'hBE, 8'hEF, 8'h5A ^ 8'hBE ^ 8'hEF, 2, 1'b0);
    flush_check("after_rst");

    // randomized traffic
    for (int it = 0; it < 48; it++) begin
      kind = $urandom_range(0, 9);
      gap  = $urandom_range(0, 15);
      c  = 8'($urandom);
      hi = 8'($urandom);
      lo = 8'($urandom);
      k  = c ^ hi ^ lo;
      if (kind < 5)      send_frame(c, hi, lo, k, gap, ($urandom_range(0, 2) == 0));
      else if (kind < 7) send_frame(c, hi, lo, k ^ (8'h01 << $urandom_range(0, 7)), gap, 1'b0);
      else if (kind < 9) send_byte(8'($urandom), gap, 1'b0);
      else               ack_only();
      if ((it % 8) == 7) flush_check("rand");
    end
    flush_check("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
